argon_mem_unit: RTL

//  Memory access unit downstream of the Argon core's memory port. Accepts one load/store/fetch

---
 rtl/argon_pkg.sv | 30 +++
 rtl/argon_mem_lane_fmt.sv | 66 ++++++
 rtl/argon_mem_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/argon_pkg.sv
// Shared definitions for the Argon memory access unit: load/store mask
// encodings, the access FSM state type and a mask normalisation helper.
package argon_pkg;

    localparam logic [2:0] RDMASK_NONE = 3'd0;
    localparam logic [2:0] RDMASK_B    = 3'd1;
    localparam logic [2:0] RDMASK_BU   = 3'd2;
    localparam logic [2:0] RDMASK_H    = 3'd3;
    localparam logic [2:0] RDMASK_HU   = 3'd4;
    localparam logic [2:0] RDMASK_W    = 3'd5;

    localparam logic [1:0] WRMASK_NONE = 2'd0;
    localparam logic [1:0] WRMASK_B    = 2'd1;
    localparam logic [1:0] WRMASK_H    = 2'd2;
    localparam logic [1:0] WRMASK_W    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        CAPTURE,
        RESP
    } mem_state_t;

    // Reserved load codes behave as "no load".
    function automatic logic [2:0] rd_mask_norm(input logic [2:0] i_mask);
        return (i_mask > RDMASK_W) ? RDMASK_NONE : i_mask;
    endfunction

endpackage

// File: rtl/argon_mem_lane_fmt.sv
// Combinational lane formatting for the Argon memory unit: store byte-enable
// and lane replication, load lane extraction with sign/zero extension.
module argon_mem_lane_fmt
    import argon_pkg::*;
(
    input  logic [1:0]  i_st_addr_lo,
    input  logic [1:0]  i_wr_mask,
    input  logic [31:0] i_wr_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [2:0]  i_rd_mask,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store: pick byte enables from the aligned offset, replicate data over all lanes
    always_comb begin
        o_st_be    = '0;
        o_st_wdata = '0;
        case (i_wr_mask)
            WRMASK_B: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_wr_data[7:0]}};
            end
            WRMASK_H: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_wr_data[15:0]}};
            end
            WRMASK_W: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_wr_data;
            end
            default: ;
        endcase
    end

    // Load: select the addressed byte and half-word lanes
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_ld_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Load: extend the selected lane to 32 bits
    always_comb begin
        o_ld_data = '0;
        case (i_rd_mask)
            RDMASK_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            RDMASK_BU: o_ld_data = {24'd0, w_byte};
            RDMASK_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            RDMASK_HU: o_ld_data = {16'd0, w_half};
            RDMASK_W:  o_ld_data = i_rdata;
            default:   o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/argon_mem_unit.sv
// Argon memory access unit: one outstanding load/store against a word-wide
// synchronous SRAM with byte enables and configurable read wait states.
// Optional feature macro: ARGON_MEM_MISALIGN_FAULT_EN (misaligned requests
// fault instead of being force-aligned).
module argon_mem_unit
    import argon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wr_data,
    input  logic [2:0]            i_rd_mask,
    input  logic [1:0]            i_wr_mask,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rd_data,
    output logic                  o_fault,
    output logic                  o_sram_en,
    output logic                  o_sram_we,
    output logic [3:0]            o_sram_be,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [31:0]           o_sram_wdata,
    input  logic [31:0]           i_sram_rdata
);

    mem_state_t            r_state;
    logic [3:0]            r_wait_cnt;
    logic                  r_is_write;
    logic [1:0]            r_ld_lo;
    logic [2:0]            r_rd_mask;
    logic [31:0]           r_rd_data;
    logic                  r_rsp_valid;
    logic                  r_sram_en;
    logic                  r_sram_we;
    logic [3:0]            r_sram_be;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [31:0]           r_sram_wdata;

    logic [2:0]  w_rd_mask;
    logic        w_do_write;
    logic        w_do_read;
    logic        w_is_half;
    logic        w_is_word;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;
    logic        w_unused_addr;

    // Address bits above the SRAM range wrap and are intentionally dropped.
    assign w_unused_addr = &{1'b0, i_addr[31:ADDR_WIDTH+2]};

    // A store takes priority; the load half of a combined request is ignored.
    assign w_rd_mask  = rd_mask_norm(i_rd_mask);
    assign w_do_write = (i_wr_mask != WRMASK_NONE);
    assign w_do_read  = !w_do_write && (w_rd_mask != RDMASK_NONE);
    assign w_is_half  = w_do_write ? (i_wr_mask == WRMASK_H)
                                   : (w_rd_mask == RDMASK_H || w_rd_mask == RDMASK_HU);
    assign w_is_word  = w_do_write ? (i_wr_mask == WRMASK_W) : (w_rd_mask == RDMASK_W);
    assign w_addr_lo  = w_is_word ? 2'b00 : (w_is_half ? {i_addr[1], 1'b0} : i_addr[1:0]);

`ifdef ARGON_MEM_MISALIGN_FAULT_EN
    logic w_misalign;
    logic r_fault;
    assign w_misalign = (w_is_half & i_addr[0]) | (w_is_word & (i_addr[1:0] != 2'b00));
    assign o_fault    = r_fault;
`else
    assign o_fault    = 1'b0;
`endif

    argon_mem_lane_fmt u_lane_fmt (
        .i_st_addr_lo (w_addr_lo),
        .i_wr_mask    (i_wr_mask),
        .i_wr_data    (i_wr_data),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_addr_lo (r_ld_lo),
        .i_rd_mask    (r_rd_mask),
        .i_rdata      (i_sram_rdata),
        .o_ld_data    (w_ld_data)
    );

    assign o_req_ready  = (r_state == IDLE);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rd_data    = r_rd_data;
    assign o_sram_en    = r_sram_en;
    assign o_sram_we    = r_sram_we;
    assign o_sram_be    = r_sram_be;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;

    // Access FSM: accept, single SRAM strobe, wait-state count, capture, respond
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_is_write   <= 1'b0;
            r_ld_lo      <= '0;
            r_rd_mask    <= RDMASK_NONE;
            r_rd_data    <= '0;
            r_rsp_valid  <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_be    <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
`ifdef ARGON_MEM_MISALIGN_FAULT_EN
            r_fault      <= 1'b0;
`endif
        end else begin
            r_sram_en   <= 1'b0;
            r_sram_we   <= 1'b0;
            r_rsp_valid <= 1'b0;
`ifdef ARGON_MEM_MISALIGN_FAULT_EN
            r_fault     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_ld_lo   <= w_addr_lo;
                        r_rd_mask <= w_rd_mask;
`ifdef ARGON_MEM_MISALIGN_FAULT_EN
                        if (w_misalign) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_fault     <= 1'b1;
                        end else
`endif
                        if (w_do_write || w_do_read) begin
                            r_state      <= ACCESS;
                            r_is_write   <= w_do_write;
                            r_sram_en    <= 1'b1;
                            r_sram_we    <= w_do_write;
                            r_sram_be    <= w_do_write ? w_st_be : 4'b1111;
                            r_sram_addr  <= i_addr[ADDR_WIDTH+1:2];
                            r_sram_wdata <= w_do_write ? w_st_wdata : '0;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (r_is_write) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_state    <= WAIT;
                        r_wait_cnt <= 4'(WAIT_STATES - 1);
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    r_rd_data   <= w_ld_data;
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
